// File: rtl/sextium_io_pkg.sv
// Shared definitions for the Sextium IO FIFO slave.
//   reg_idx_e         : Avalon register index decode (STATUS/RXDATA/TXDATA/reserved)
//   STAT_*            : STATUS register bit positions
//   DEPTH_LOG2_DEFAULT: default log2 FIFO depth
package sextium_io_pkg;

  typedef enum logic [1:0] {
    REG_STATUS = 2'd0,
    REG_RXDATA = 2'd1,
    REG_TXDATA = 2'd2,
    REG_RSVD   = 2'd3
  } reg_idx_e;

  localparam int unsigned STAT_RX_NONEMPTY = 0;
  localparam int unsigned STAT_TX_NONFULL  = 1;
  localparam int unsigned STAT_DROP        = 2;
  localparam int unsigned STAT_RXCNT_LSB   = 8;
  localparam int unsigned STAT_RXCNT_MSB   = 15;

  localparam int unsigned DEPTH_LOG2_DEFAULT = 4;

endpackage

// File: rtl/sextium_sync_fifo.sv
// Synchronous show-ahead FIFO with registered storage.
//   clk_i, rst_i      : clock, asynchronous active-high reset (clears pointers/count)
//   push_i/push_data_i: write request and data; ignored while full
//   pop_i             : read request; ignored while empty
//   full_o, empty_o   : status flags
//   count_o           : occupancy, DEPTH_LOG2+1 bits
//   head_o            : oldest entry, combinationally visible
module sextium_sync_fifo #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [DATA_W-1:0]     push_data_i,
  input  logic                  pop_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic [DATA_W-1:0]     head_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
  localparam logic [DEPTH_LOG2:0]   CNT_ONE = 1;

  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  do_push, do_pop;

  // Occupancy never exceeds DEPTH, so the MSB alone marks full.
  assign full_o  = count_q[DEPTH_LOG2];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (do_push && !do_pop) count_d = count_q + CNT_ONE;
    if (do_pop && !do_push) count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/sextium_avalon_fifo_slave.sv
// Avalon-MM slave for the Sextium IO FIFO window.
//   clk, reset            : clock, asynchronous active-high reset
//   address/read/write/
//   writedata/byteenable  : Avalon-MM slave request (byteenable ignored)
//   readdata/waitrequest  : Avalon-MM response; empty-RX reads and full-TX
//                           writes stall unless non-blocking mode is built
//   rx_in_*               : inbound 16-bit stream feeding the RX FIFO
//   tx_out_*              : outbound 16-bit stream drained from the TX FIFO
// Build option: define SEXTIUM_IO_NONBLOCK_EN for non-blocking IO with a
// sticky drop flag in STATUS bit2 (cleared by a STATUS read).
module sextium_avalon_fifo_slave
  import sextium_io_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEFAULT,
  parameter int unsigned DATA_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        address,
  input  logic              read,
  output logic [31:0]       readdata,
  output logic              waitrequest,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  input  logic [DATA_W-1:0] rx_in_data,
  input  logic              rx_in_valid,
  output logic              rx_in_ready,
  output logic [DATA_W-1:0] tx_out_data,
  output logic              tx_out_valid,
  input  logic              tx_out_ready
);

  logic                rx_full, rx_empty, rx_pop;
  logic                tx_full, tx_empty, tx_push;
  logic [DEPTH_LOG2:0] rx_count, tx_count;
  logic [DATA_W-1:0]   rx_head, tx_head;
  logic                rd_status, rd_rx, wr_tx;
  logic                drop_flag;
  logic [31:0]         status;
  logic                unused_ok;

  assign unused_ok = ^{byteenable, writedata[31:DATA_W], tx_count};

  // A concurrent read wins: the write is excluded from all decode.
  assign rd_status = read & (address == REG_STATUS);
  assign rd_rx     = read & (address == REG_RXDATA);
  assign wr_tx     = write & ~read & (address == REG_TXDATA);

  assign rx_pop  = rd_rx & ~rx_empty;
  assign tx_push = wr_tx & ~tx_full;

  assign rx_in_ready  = ~rx_full;
  assign tx_out_valid = ~tx_empty;
  assign tx_out_data  = tx_head;

  sextium_sync_fifo #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clk_i       (clk),
    .rst_i       (reset),
    .push_i      (rx_in_valid),
    .push_data_i (rx_in_data),
    .pop_i       (rx_pop),
    .full_o      (rx_full),
    .empty_o     (rx_empty),
    .count_o     (rx_count),
    .head_o      (rx_head)
  );

  sextium_sync_fifo #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clk_i       (clk),
    .rst_i       (reset),
    .push_i      (tx_push),
    .push_data_i (writedata[DATA_W-1:0]),
    .pop_i       (tx_out_ready),
    .full_o      (tx_full),
    .empty_o     (tx_empty),
    .count_o     (tx_count),
    .head_o      (tx_head)
  );

  always_comb begin
    status = '0;
    status[STAT_RX_NONEMPTY] = ~rx_empty;
    status[STAT_TX_NONFULL]  = ~tx_full;
    status[STAT_DROP]        = drop_flag;
    status[STAT_RXCNT_MSB:STAT_RXCNT_LSB] = 8'(rx_count);
  end

  always_comb begin
    readdata = '0;
    if (read) begin
      case (address)
        REG_STATUS: readdata = status;
        REG_RXDATA: if (!rx_empty) readdata = {{(32-DATA_W){1'b0}}, rx_head};
        default:    readdata = '0;
      endcase
    end
  end

`ifdef SEXTIUM_IO_NONBLOCK_EN
  logic drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    if (rd_status)        drop_d = 1'b0;
    if (wr_tx && tx_full) drop_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) drop_q <= 1'b0;
    else       drop_q <= drop_d;
  end

  assign drop_flag   = drop_q;
  assign waitrequest = 1'b0;
`else
  assign drop_flag = 1'b0;
  // Held low during reset so a stalled master is released.
  assign waitrequest = ~reset &
                       (read ? ((address == REG_RXDATA) & rx_empty)
                             : (write & (address == REG_TXDATA) & tx_full));
`endif

endmodule

// File: tb/tb_sextium_avalon_fifo_slave.sv
module tb_sextium_avalon_fifo_slave;
  import sextium_io_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        read, write;
  logic [31:0] readdata, writedata;
  logic        waitrequest;
  logic [3:0]  byteenable;
  logic [15:0] rx_in_data, tx_out_data;
  logic        rx_in_valid, rx_in_ready, tx_out_valid, tx_out_ready;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_rd[$];
  logic [15:0] exp_tx[$];
  logic [15:0] rx_model[$];

  always #5 clk = ~clk;

  sextium_avalon_fifo_slave #(.DEPTH_LOG2(4), .DATA_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .address      (address),
    .read         (read),
    .readdata     (readdata),
    .waitrequest  (waitrequest),
    .write        (write),
    .writedata    (writedata),
    .byteenable   (byteenable),
    .rx_in_data   (rx_in_data),
    .rx_in_valid  (rx_in_valid),
    .rx_in_ready  (rx_in_ready),
    .tx_out_data  (tx_out_data),
    .tx_out_valid (tx_out_valid),
    .tx_out_ready (tx_out_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: compares every completed read and every stream beat.
  always @(negedge clk) begin
    if (!reset) begin
      if (read && !waitrequest) begin
        if (exp_rd.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_unexpected: got %h expected none", readdata);
        end else chk("readdata", readdata, exp_rd.pop_front());
      end
      if (tx_out_valid && tx_out_ready) begin
        if (exp_tx.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_unexpected: got %h expected none", tx_out_data);
        end else chk("tx_out_data", {16'h0, tx_out_data}, {16'h0, exp_tx.pop_front()});
      end
    end
  end

  task automatic avl_read(input logic [1:0] a, input logic [31:0] e, output int waits);
    exp_rd.push_back(e);
    address = a; read = 1'b1; waits = 0;
    while (1) begin
      @(negedge clk);
      if (!waitrequest) break;
      waits++;
      if (waits >= 200) begin
        checks++; errors++;
        $display("FAIL rd_timeout: got stalled expected completion");
        void'(exp_rd.pop_back());
        break;
      end
    end
    @(posedge clk); #1 read = 1'b0;
  endtask

  task automatic avl_write(input logic [1:0] a, input logic [15:0] d, input bit emits,
                           output int waits);
    if (emits) exp_tx.push_back(d);
    address = a; writedata = {16'hA5A5, d}; write = 1'b1; waits = 0;
    while (1) begin
      @(negedge clk);
      if (!waitrequest) break;
      waits++;
      if (waits >= 200) begin
        checks++; errors++;
        $display("FAIL wr_timeout: got stalled expected completion");
        break;
      end
    end
    @(posedge clk); #1 write = 1'b0;
  endtask

  task automatic rx_push(input logic [15:0] d);
    int n = 0;
    rx_in_data = d; rx_in_valid = 1'b1;
    while (1) begin
      @(negedge clk);
      if (rx_in_ready) break;
      n++;
      if (n >= 200) begin
        checks++; errors++;
        $display("FAIL rx_push_timeout: got ready=0 expected ready=1");
        break;
      end
    end
    @(posedge clk); #1 rx_in_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    reset = 1'b1; address = '0; read = 1'b0; write = 1'b0; writedata = '0;
    byteenable = 4'b0011; rx_in_data = '0; rx_in_valid = 1'b0; tx_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_waitrequest", {31'h0, waitrequest}, 32'h0);
    chk("rst_tx_valid", {31'h0, tx_out_valid}, 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("post_rst_readdata", readdata, 32'h0);
    chk("post_rst_rx_ready", {31'h0, rx_in_ready}, 32'h1);
    chk("post_rst_tx_valid", {31'h0, tx_out_valid}, 32'h0);
    chk("post_rst_waitrequest", {31'h0, waitrequest}, 32'h0);
    @(posedge clk); #1;

    avl_read(REG_STATUS, 32'h0000_0002, w); chk("status_wait", w, 0);

    rx_push(16'h1234);
    rx_push(16'hBEEF);
    avl_read(REG_RXDATA, 32'h0000_1234, w); chk("rx1_wait", w, 0);
    avl_read(REG_RXDATA, 32'h0000_BEEF, w); chk("rx2_wait", w, 0);
    avl_read(REG_STATUS, 32'h0000_0002, w);

`ifndef SEXTIUM_IO_NONBLOCK_EN
    fork
      avl_read(REG_RXDATA, 32'h0000_00A5, w);
      begin repeat (3) @(posedge clk); #1 rx_push(16'h00A5); end
    join
    chk("rx_stall_waits", w, 4);
`else
    avl_read(REG_RXDATA, 32'h0000_0000, w); chk("nb_rx_empty_wait", w, 0);
`endif

    for (int i = 0; i < 16; i++) begin
      avl_write(REG_TXDATA, 16'(i), 1'b1, w);
      chk("tx_fill_wait", w, 0);
      if (i == 0) chk("tx_valid_next", {31'h0, tx_out_valid}, 32'h1);
    end
    avl_read(REG_STATUS, 32'h0000_0000, w);

`ifndef SEXTIUM_IO_NONBLOCK_EN
    fork
      avl_write(REG_TXDATA, 16'h0010, 1'b1, w);
      begin repeat (2) @(posedge clk); #1 tx_out_ready = 1'b1; end
    join
    chk("tx_stall_waits", w, 3);
`else
    avl_write(REG_TXDATA, 16'hDEAD, 1'b0, w); chk("nb_tx_full_wait", w, 0);
    avl_read(REG_STATUS, 32'h0000_0004, w);
    avl_read(REG_STATUS, 32'h0000_0000, w);
    tx_out_ready = 1'b1;
`endif

    for (int n = 0; n < 100 && (exp_tx.size() != 0 || tx_out_valid); n++) @(posedge clk);
    #1;
    chk("tx_drained_queue", exp_tx.size(), 0);
    chk("tx_drained_valid", {31'h0, tx_out_valid}, 32'h0);

    for (int i = 0; i < 16; i++) begin
      rx_push(16'h0100 + 16'(i));
      rx_model.push_back(16'h0100 + 16'(i));
    end
    @(negedge clk);
    chk("rx_full_ready", {31'h0, rx_in_ready}, 32'h0);
    @(posedge clk); #1;
    avl_read(REG_STATUS, 32'h0000_1003, w);
    avl_read(REG_RXDATA, {16'h0, rx_model.pop_front()}, w); chk("rx_full_pop_wait", w, 0);
    @(negedge clk);
    chk("rx_ready_after_pop", {31'h0, rx_in_ready}, 32'h1);
    @(posedge clk); #1;

    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) begin
        rx_push(16'h0200 + 16'(i));
        rx_model.push_back(16'h0200 + 16'(i));
      end else begin
        avl_read(REG_RXDATA, {16'h0, rx_model.pop_front()}, w);
      end
    end
    avl_read(REG_STATUS, {16'h0, 8'(rx_model.size()), 8'h03}, w);
    while (rx_model.size() != 0) avl_read(REG_RXDATA, {16'h0, rx_model.pop_front()}, w);
    avl_read(REG_STATUS, 32'h0000_0002, w);

    avl_read(REG_RSVD, 32'h0000_0000, w); chk("rsvd_read_wait", w, 0);
    avl_write(REG_STATUS, 16'hFFFF, 1'b0, w); chk("status_write_wait", w, 0);
    avl_write(REG_RSVD, 16'h7777, 1'b0, w);
    avl_read(REG_STATUS, 32'h0000_0002, w);
    repeat (3) @(posedge clk); #1;
    chk("no_stray_tx", {31'h0, tx_out_valid}, 32'h0);
    chk("rd_queue_empty", exp_rd.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
